multiplier_arbiter: RTL and testbench

MULTIPLIER_ARBITER -- requirements
Module: multiplier_arbiter

---
 rtl/multiplier_arbiter_pkg.sv | 15 +
 rtl/rr_priority_encoder.sv | 34 +++
 rtl/multiplier_arbiter.sv | 131 +++++++++++++
 tb/tb_multiplier_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multiplier_arbiter_pkg.sv
// Shared types for the multiplier arbiter: element width, the complex 2x2
// matrix layout [row][col][re/im] and the arbiter FSM states.
package multiplier_arbiter_pkg;

    localparam int NUMERIC_BITS = 19;

    typedef logic signed [1:0][1:0][1:0][NUMERIC_BITS-1:0] cmtx_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

endpackage

// File: rtl/rr_priority_encoder.sv
// Round-robin winner selection: first set pending bit at or after rr_ptr,
// wrapping modulo NUM_REQ. Purely combinational.
module rr_priority_encoder #(
    parameter int NUM_REQ  = 2,
    parameter int REQ_BITS = 1
) (
    input  logic [NUM_REQ-1:0]  pending,
    input  logic [REQ_BITS-1:0] rr_ptr,
    output logic [REQ_BITS-1:0] winner,
    output logic                valid
);
    import multiplier_arbiter_pkg::*;

    // One extra bit so rr_ptr + offset never overflows before the wrap.
    logic [REQ_BITS:0] pos;

    // Scan offsets 0..NUM_REQ-1 from rr_ptr; the first pending hit wins.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        pos    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = {1'b0, rr_ptr} + (REQ_BITS+1)'(k);
            if (pos >= (REQ_BITS+1)'(NUM_REQ)) begin
                pos = pos - (REQ_BITS+1)'(NUM_REQ);
            end
            if (!valid && pending[pos[REQ_BITS-1:0]]) begin
                winner = pos[REQ_BITS-1:0];
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/multiplier_arbiter.sv
// Shares one complex 2x2 matrix multiplier between NUM_REQ requesters.
// Requests are latched as pending bits, served round-robin; the winner's
// operands are captured so the requester is free once granted.
module multiplier_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int NUMERIC_BITS = multiplier_arbiter_pkg::NUMERIC_BITS,
    parameter int REQ_BITS     = 1
) (
    input  logic                                                     clk,
    input  logic                                                     reset,
    input  logic [NUM_REQ-1:0]                                       req_ready,
    input  logic signed [NUM_REQ-1:0][1:0][1:0][1:0][NUMERIC_BITS-1:0] req_a,
    input  logic signed [NUM_REQ-1:0][1:0][1:0][1:0][NUMERIC_BITS-1:0] req_b,
    output logic [NUM_REQ-1:0]                                       req_done,
    output logic signed [1:0][1:0][1:0][NUMERIC_BITS-1:0]            result_mtx,
    output logic [REQ_BITS-1:0]                                      grant_idx,
    output logic                                                     busy,
    output logic signed [1:0][1:0][1:0][NUMERIC_BITS-1:0]            multiplier_a,
    output logic signed [1:0][1:0][1:0][NUMERIC_BITS-1:0]            multiplier_b,
    output logic                                                     multiplier_ready,
    input  logic                                                     multiplier_done,
    input  logic signed [1:0][1:0][1:0][NUMERIC_BITS-1:0]            multiplier_result
);
    import multiplier_arbiter_pkg::*;

    state_t                state_q;
    state_t                state_d;
    logic [NUM_REQ-1:0]    pending;
    logic [NUM_REQ-1:0]    pending_d;
    logic [NUM_REQ-1:0]    grant_mask;
    logic [NUM_REQ-1:0]    done_mask;
    logic [REQ_BITS-1:0]   rr_ptr;
    logic [REQ_BITS-1:0]   next_ptr;
    logic [REQ_BITS-1:0]   winner;
    logic                  win_valid;
    logic                  grant;
    logic                  accept;

    rr_priority_encoder #(
        .NUM_REQ  (NUM_REQ),
        .REQ_BITS (REQ_BITS)
    ) u_rr_enc (
        .pending (pending),
        .rr_ptr  (rr_ptr),
        .winner  (winner),
        .valid   (win_valid)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the grant/accept strobes and multiplier handshake.
    always_comb begin
        state_d          = state_q;
        grant            = 1'b0;
        accept           = 1'b0;
        multiplier_ready = 1'b0;
        busy             = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    grant   = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                multiplier_ready = 1'b1;
                busy             = 1'b1;
                state_d          = ST_WAIT;
            end
            ST_WAIT: begin
                busy = 1'b1;
                // A done pulse outside WAIT is stray and falls through.
                if (multiplier_done) begin
                    accept  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pending update (grant clear beats a same-cycle duplicate pulse),
    // completion one-hot and the round-robin pointer advance.
    always_comb begin
        grant_mask = '0;
        done_mask  = '0;
        if (grant) begin
            grant_mask[winner] = 1'b1;
        end
        done_mask[grant_idx] = 1'b1;
        pending_d = (pending | req_ready) & ~grant_mask;
        if (grant_idx == REQ_BITS'(NUM_REQ - 1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = grant_idx + REQ_BITS'(1);
        end
    end

    // Arbitration state, operand capture and result register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending      <= '0;
            rr_ptr       <= '0;
            grant_idx    <= '0;
            req_done     <= '0;
            multiplier_a <= '0;
            multiplier_b <= '0;
            result_mtx   <= '0;
        end else begin
            pending  <= pending_d;
            req_done <= accept ? done_mask : '0;
            if (grant) begin
                grant_idx    <= winner;
                multiplier_a <= req_a[winner];
                multiplier_b <= req_b[winner];
            end
            if (accept) begin
                result_mtx <= multiplier_result;
                rr_ptr     <= next_ptr;
            end
        end
    end

endmodule

// File: tb/tb_multiplier_arbiter.sv
// Bench for multiplier_arbiter with four requesters: directed scenarios plus
// a randomized run against a transaction-level round-robin model.
module tb_multiplier_arbiter;
    import multiplier_arbiter_pkg::*;

    localparam int NR = 4;
    localparam int RB = 2;
    localparam int NB = NUMERIC_BITS;

    logic                                  clk;
    logic                                  reset;
    logic [NR-1:0]                         req_ready;
    logic signed [NR-1:0][1:0][1:0][1:0][NB-1:0] req_a;
    logic signed [NR-1:0][1:0][1:0][1:0][NB-1:0] req_b;
    logic [NR-1:0]                         req_done;
    cmtx_t                                 result_mtx;
    logic [RB-1:0]                         grant_idx;
    logic                                  busy;
    cmtx_t                                 multiplier_a;
    cmtx_t                                 multiplier_b;
    logic                                  multiplier_ready;
    logic                                  multiplier_done;
    cmtx_t                                 multiplier_result;

    int checks   = 0;
    int failures = 0;

    multiplier_arbiter #(
        .NUM_REQ      (NR),
        .NUMERIC_BITS (NB),
        .REQ_BITS     (RB)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .req_ready         (req_ready),
        .req_a             (req_a),
        .req_b             (req_b),
        .req_done          (req_done),
        .result_mtx        (result_mtx),
        .grant_idx         (grant_idx),
        .busy              (busy),
        .multiplier_a      (multiplier_a),
        .multiplier_b      (multiplier_b),
        .multiplier_ready  (multiplier_ready),
        .multiplier_done   (multiplier_done),
        .multiplier_result (multiplier_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic cmtx_t rand_mtx();
        cmtx_t m;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
                for (int p = 0; p < 2; p++)
                    m[r][c][p] = NB'($urandom);
        return m;
    endfunction

    task automatic do_reset();
        reset             = 1'b1;
        req_ready         = '0;
        multiplier_done   = 1'b0;
        multiplier_result = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        req_a = '0;
        req_b = '0;
        do_reset();
        reset = 1'b1;
        tick();
        checks++; if (req_done !== '0) begin failures++; $display("FAIL reset_req_done got=%b exp=0", req_done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (multiplier_ready !== 1'b0) begin failures++; $display("FAIL reset_mready got=%b exp=0", multiplier_ready); end
        checks++; if (grant_idx !== '0) begin failures++; $display("FAIL reset_grant got=%0d exp=0", grant_idx); end
        checks++; if (result_mtx !== '0) begin failures++; $display("FAIL reset_result got=%h exp=0", result_mtx); end
        checks++; if (multiplier_a !== '0 || multiplier_b !== '0) begin failures++; $display("FAIL reset_operands got=%h/%h exp=0", multiplier_a, multiplier_b); end
        reset = 1'b0;
        // Stray done while idle must be ignored.
        multiplier_done   = 1'b1;
        multiplier_result = rand_mtx();
        tick();
        multiplier_done = 1'b0;
        checks++; if (req_done !== '0) begin failures++; $display("FAIL idle_stray_done got=%b exp=0", req_done); end
        checks++; if (result_mtx !== '0) begin failures++; $display("FAIL idle_stray_result got=%h exp=0", result_mtx); end
    endtask

    task automatic test_single();
        cmtx_t ident, hada, junk;
        ident = '0; ident[0][0][0] = 19'h04000; ident[1][1][0] = 19'h04000;
        hada  = '0; hada[0][0][0]  = 19'h04000; hada[0][1][0]  = 19'h04000;
        hada[1][0][0] = 19'h04000; hada[1][1][0] = 19'h7C000;
        junk = rand_mtx();
        do_reset();
        req_a[0] = ident; req_b[0] = hada; req_ready = 4'b0001;          // cycle 0
        tick(); req_ready = '0;                                           // cycle 1
        checks++; if (multiplier_ready !== 1'b0) begin failures++; $display("FAIL single_early_ready got=%b exp=0", multiplier_ready); end
        tick();                                                           // cycle 2
        checks++; if (multiplier_ready !== 1'b1) begin failures++; $display("FAIL single_ready_c2 got=%b exp=1", multiplier_ready); end
        checks++; if (busy !== 1'b1 || grant_idx !== 2'd0) begin failures++; $display("FAIL single_busy_grant got=%b/%0d exp=1/0", busy, grant_idx); end
        checks++; if (multiplier_a !== ident) begin failures++; $display("FAIL single_op_a got=%h exp=%h", multiplier_a, ident); end
        checks++; if (multiplier_b !== hada) begin failures++; $display("FAIL single_op_b got=%h exp=%h", multiplier_b, hada); end
        req_a[0] = junk;                       // requester may move on once granted
        multiplier_done = 1'b1; multiplier_result = junk;                 // stray in ISSUE
        tick(); multiplier_done = 1'b0;                                   // cycle 3
        checks++; if (multiplier_ready !== 1'b0 || req_done !== '0) begin failures++; $display("FAIL issue_stray got ready=%b done=%b exp 0/0", multiplier_ready, req_done); end
        checks++; if (result_mtx !== '0) begin failures++; $display("FAIL issue_stray_result got=%h exp=0", result_mtx); end
        checks++; if (multiplier_a !== ident) begin failures++; $display("FAIL single_captured_a got=%h exp=%h", multiplier_a, ident); end
        tick(); tick();                                                   // cycle 5
        multiplier_done = 1'b1; multiplier_result = hada;
        tick(); multiplier_done = 1'b0; multiplier_result = junk;         // cycle 6
        checks++; if (req_done !== 4'b0001) begin failures++; $display("FAIL single_done_c6 got=%b exp=0001", req_done); end
        checks++; if (result_mtx !== hada) begin failures++; $display("FAIL single_result got=%h exp=%h", result_mtx, hada); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle got=%b exp=0", busy); end
        tick();                                                           // cycle 7
        checks++; if (req_done !== '0) begin failures++; $display("FAIL single_done_once got=%b exp=0", req_done); end
        checks++; if (result_mtx !== hada) begin failures++; $display("FAIL single_result_hold got=%h exp=%h", result_mtx, hada); end
    endtask

    task automatic test_simultaneous();
        cmtx_t a0, a1, r0, r1, res;
        int n, exp_w;
        a0 = rand_mtx(); a1 = rand_mtx(); r0 = rand_mtx(); r1 = rand_mtx();
        do_reset();
        req_a[0] = a0; req_a[1] = a1; req_b[0] = rand_mtx(); req_b[1] = rand_mtx();
        req_ready = 4'b0011;                                              // cycle 0
        tick(); req_ready = '0;
        tick();                                                           // cycle 2
        checks++; if (multiplier_ready !== 1'b1 || grant_idx !== 2'd0) begin failures++; $display("FAIL simul_first got ready=%b grant=%0d exp 1/0", multiplier_ready, grant_idx); end
        checks++; if (multiplier_a !== a0) begin failures++; $display("FAIL simul_op_a0 got=%h exp=%h", multiplier_a, a0); end
        tick(); tick(); multiplier_done = 1'b1; multiplier_result = r0;   // cycle 4
        tick(); multiplier_done = 1'b0;                                   // cycle 5
        checks++; if (req_done !== 4'b0001 || result_mtx !== r0) begin failures++; $display("FAIL simul_done0 got=%b %h exp=0001 %h", req_done, result_mtx, r0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL simul_idle_gap got=%b exp=0", busy); end
        tick();                                                           // cycle 6
        checks++; if (multiplier_ready !== 1'b1 || grant_idx !== 2'd1) begin failures++; $display("FAIL simul_second got ready=%b grant=%0d exp 1/1", multiplier_ready, grant_idx); end
        checks++; if (multiplier_a !== a1) begin failures++; $display("FAIL simul_op_a1 got=%h exp=%h", multiplier_a, a1); end
        tick(); multiplier_done = 1'b1; multiplier_result = r1;           // cycle 7
        tick(); multiplier_done = 1'b0;                                   // cycle 8
        checks++; if (req_done !== 4'b0010 || result_mtx !== r1) begin failures++; $display("FAIL simul_done1 got=%b %h exp=0010 %h", req_done, result_mtx, r1); end
        // Pointer now sits after requester 1: all four pending serve 2,3,0,1.
        req_ready = 4'b1111;
        tick(); req_ready = '0;
        for (int k = 0; k < NR; k++) begin
            exp_w = (2 + k) % NR;
            n = 0;
            while (multiplier_ready !== 1'b1 && n < 16) begin tick(); n++; end
            checks++; if (multiplier_ready !== 1'b1) begin failures++; $display("FAIL rr_timeout got ready=%b exp=1", multiplier_ready); end
            checks++; if (grant_idx !== RB'(exp_w)) begin failures++; $display("FAIL rr_order got=%0d exp=%0d", grant_idx, exp_w); end
            tick(); multiplier_done = 1'b1; res = rand_mtx(); multiplier_result = res;
            tick(); multiplier_done = 1'b0;
            checks++; if (req_done !== (NR'(1) << exp_w) || result_mtx !== res) begin failures++; $display("FAIL rr_done got=%b exp=%b", req_done, NR'(1) << exp_w); end
        end
    endtask

    task automatic test_fairness();
        cmtx_t res;
        int n;
        do_reset();
        req_ready = 4'b0011;
        tick(); req_ready = '0;
        for (int k = 0; k < 6; k++) begin
            n = 0;
            while (multiplier_ready !== 1'b1 && n < 16) begin tick(); n++; end
            checks++; if (multiplier_ready !== 1'b1) begin failures++; $display("FAIL fair_timeout got ready=%b exp=1", multiplier_ready); end
            checks++; if (grant_idx !== RB'(k % 2)) begin failures++; $display("FAIL fair_order svc%0d got=%0d exp=%0d", k, grant_idx, k % 2); end
            tick(); tick(); multiplier_done = 1'b1; res = rand_mtx(); multiplier_result = res;
            tick(); multiplier_done = 1'b0;
            checks++; if (req_done !== (NR'(1) << (k % 2))) begin failures++; $display("FAIL fair_done got=%b exp=%b", req_done, NR'(1) << (k % 2)); end
            req_ready = NR'(1) << (k % 2);
            tick(); req_ready = '0;
        end
    endtask

    task automatic test_duplicate();
        int rdy_cnt, done0, done1, cd;
        rdy_cnt = 0; done0 = 0; done1 = 0; cd = 0;
        do_reset();
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (multiplier_ready === 1'b1) rdy_cnt++;
            if (req_done[0] === 1'b1) done0++;
            if (req_done[1] === 1'b1) done1++;
            checks++; if (!$onehot0(req_done)) begin failures++; $display("FAIL dup_onehot got=%b exp=one-hot", req_done); end
            req_ready = (cyc == 0) ? 4'b0001 : ((cyc == 1 || cyc == 3) ? 4'b0010 : 4'b0000);
            multiplier_done = 1'b0;
            if (cd == 1) multiplier_done = 1'b1;
            if (cd > 0) cd--;
            if (multiplier_ready === 1'b1) cd = 2;
            tick();
        end
        req_ready = '0;
        checks++; if (rdy_cnt != 2) begin failures++; $display("FAIL dup_ready_count got=%0d exp=2", rdy_cnt); end
        checks++; if (done1 != 1 || done0 != 1) begin failures++; $display("FAIL dup_done_count got=%0d/%0d exp=1/1", done0, done1); end
    endtask

    task automatic test_reset_wait();
        do_reset();
        req_ready = 4'b0100;
        tick(); req_ready = '0;
        tick();                                                           // ISSUE
        tick();                                                           // WAIT
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rstwait_busy got=%b exp=1", busy); end
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || grant_idx !== '0 || multiplier_a !== '0) begin failures++; $display("FAIL rstwait_async got busy=%b grant=%0d", busy, grant_idx); end
        tick(); reset = 1'b0;
        tick(); tick();
        multiplier_done = 1'b1; multiplier_result = rand_mtx();
        tick(); multiplier_done = 1'b0;
        checks++; if (req_done !== '0 || result_mtx !== '0) begin failures++; $display("FAIL rstwait_stray got done=%b result=%h exp 0/0", req_done, result_mtx); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (req_done !== '0 || multiplier_ready !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rstwait_quiet got done=%b ready=%b busy=%b", req_done, multiplier_ready, busy); end
        end
    endtask

    task automatic test_coincide();
        cmtx_t a_new, r0, r1;
        a_new = rand_mtx(); r0 = rand_mtx(); r1 = rand_mtx();
        do_reset();
        req_a[2] = rand_mtx();
        req_ready = 4'b0100;
        tick(); req_ready = '0;
        tick();
        checks++; if (multiplier_ready !== 1'b1 || grant_idx !== 2'd2) begin failures++; $display("FAIL coin_first got ready=%b grant=%0d exp 1/2", multiplier_ready, grant_idx); end
        tick(); tick();
        multiplier_done = 1'b1; multiplier_result = r0;
        req_ready = 4'b0100; req_a[2] = a_new;
        tick(); multiplier_done = 1'b0; req_ready = '0;
        checks++; if (req_done !== 4'b0100 || result_mtx !== r0) begin failures++; $display("FAIL coin_done got=%b exp=0100", req_done); end
        tick();
        checks++; if (multiplier_ready !== 1'b1 || grant_idx !== 2'd2) begin failures++; $display("FAIL coin_reissue got ready=%b grant=%0d exp 1/2", multiplier_ready, grant_idx); end
        checks++; if (multiplier_a !== a_new) begin failures++; $display("FAIL coin_op_a got=%h exp=%h", multiplier_a, a_new); end
        tick(); tick();
        multiplier_done = 1'b1; multiplier_result = r1;
        tick(); multiplier_done = 1'b0;
        checks++; if (req_done !== 4'b0100 || result_mtx !== r1) begin failures++; $display("FAIL coin_done2 got=%b exp=0100", req_done); end
    endtask

    task automatic test_random();
        logic [NR-1:0] m_pend, last_pulse, exp_done;
        cmtx_t exp_a[NR], exp_b[NR];
        cmtx_t cur_res, sent_res;
        int m_ptr, owner, cd, win, served;
        bit expect_done, must_grant, was_done;
        do_reset();
        req_a = '0; req_b = '0;
        for (int i = 0; i < NR; i++) begin exp_a[i] = '0; exp_b[i] = '0; end
        m_pend = '0; last_pulse = '0; m_ptr = 0; owner = 0; cd = 0; served = 0;
        cur_res = '0; sent_res = '0; expect_done = 1'b0; must_grant = 1'b0;
        for (int cyc = 0; cyc < 900; cyc++) begin
            exp_done = '0;
            was_done = expect_done;
            if (expect_done) begin
                exp_done = NR'(1) << owner;
                cur_res  = sent_res;
                m_ptr    = (owner + 1) % NR;
                served++;
            end
            checks++; if (req_done !== exp_done) begin failures++; $display("FAIL rand_req_done cyc%0d got=%b exp=%b", cyc, req_done, exp_done); end
            checks++; if (result_mtx !== cur_res) begin failures++; $display("FAIL rand_result cyc%0d got=%h exp=%h", cyc, result_mtx, cur_res); end
            if (must_grant) begin
                checks++; if (multiplier_ready !== 1'b1) begin failures++; $display("FAIL rand_idle_gap cyc%0d got ready=%b exp=1", cyc, multiplier_ready); end
            end
            win = -1;
            if (multiplier_ready === 1'b1) begin
                for (int k = 0; k < NR; k++)
                    if (win < 0 && m_pend[(m_ptr + k) % NR]) win = (m_ptr + k) % NR;
                checks++;
                if (win < 0) begin
                    failures++; $display("FAIL rand_spurious_ready cyc%0d got grant=%0d exp no grant", cyc, grant_idx);
                end else if (grant_idx !== RB'(win) || multiplier_a !== exp_a[win] || multiplier_b !== exp_b[win]) begin
                    failures++; $display("FAIL rand_grant cyc%0d got=%0d exp=%0d", cyc, grant_idx, win);
                end
                owner = int'(grant_idx);
            end
            m_pend = m_pend | last_pulse;
            if (win >= 0) m_pend[win] = 1'b0;
            must_grant = was_done && (m_pend != '0);
            // Multiplier model: random latency, occasional stray done outside WAIT.
            expect_done = 1'b0;
            multiplier_done = 1'b0;
            multiplier_result = rand_mtx();
            if (multiplier_ready === 1'b1) begin
                cd = $urandom_range(1, 4);
                if ($urandom_range(0, 3) == 0) multiplier_done = 1'b1;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    multiplier_done = 1'b1;
                    sent_res = rand_mtx();
                    multiplier_result = sent_res;
                    expect_done = 1'b1;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                multiplier_done = 1'b1;
            end
            last_pulse = '0;
            req_ready = '0;
            if (cyc < 800) begin
                for (int i = 0; i < NR; i++) begin
                    if ($urandom_range(0, 5) == 0) begin
                        if (!m_pend[i]) begin
                            exp_a[i] = rand_mtx(); exp_b[i] = rand_mtx();
                            req_a[i] = exp_a[i];   req_b[i] = exp_b[i];
                        end
                        req_ready[i]  = 1'b1;
                        last_pulse[i] = 1'b1;
                    end
                end
            end
            tick();
        end
        req_ready = '0; multiplier_done = 1'b0;
        checks++; if (m_pend != '0 || busy !== 1'b0) begin failures++; $display("FAIL rand_drain got pend=%b busy=%b exp 0/0", m_pend, busy); end
        checks++; if (served < 20) begin failures++; $display("FAIL rand_throughput got=%0d exp>=20", served); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_duplicate();
        test_reset_wait();
        test_coincide();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
